ads131_frame_receiver: RTL

//  Downstream MISO stage of the SPI master. Deserializes ADS131A0X response frames
//  (status word + channel words, MSB first) framed by SPI_CS low. Publishes the
//  16-bit status and streams 24-bit channel samples through a FIFO with valid/ready.

---
 rtl/ads131_pkg.sv | 29 ++
 rtl/ads131_sample_fifo.sv | 59 +++++
 rtl/ads131_frame_receiver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ads131_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ads131_pkg                                               |
// | Description : Shared constants and FSM encoding for the ADS131 MISO    |
// |               frame receiver.                                          |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
package ads131_pkg;

    localparam int ADS_WORD_BITS  = 32;
    localparam int ADS_DATA_BITS  = 24;
    localparam int ADS_NUM_WORDS  = 5;
    localparam int ADS_FIFO_DEPTH = 8;

    localparam logic [15:0] STATUS_READY      = 16'hFF04;
    localparam logic [15:0] STATUS_UNLOCK_ACK = 16'h0655;
    localparam logic [15:0] STATUS_WAKEUP_ACK = 16'h0033;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'd0,
        ST_SHIFT = 5'd1,
        ST_STORE = 5'd2,
        ST_DONE  = 5'd3,
        ST_ABORT = 5'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/ads131_sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ads131_sample_fifo                                       |
// | Description : Synchronous first-word-fall-through FIFO for channel     |
// |               samples; head reads as zero while empty.                 |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module ads131_sample_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_pop;
    logic             w_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_pop   = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push  = push_i && (!full_o || w_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ads131_frame_receiver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ads131_frame_receiver                                    |
// | Description : Deserializes ADS131A0X MISO frames into a status word    |
// |               and a valid/ready stream of channel samples.             |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module ads131_frame_receiver
    import ads131_pkg::*;
#(
    parameter int WORD_BITS  = ADS_WORD_BITS,
    parameter int DATA_BITS  = ADS_DATA_BITS,
    parameter int NUM_WORDS  = ADS_NUM_WORDS,
    parameter int FIFO_DEPTH = ADS_FIFO_DEPTH
) (
    input  logic                 synthesized_clock_4_167Mhz,
    input  logic                 reset_n,
    input  logic                 spi_cs_n,
    input  logic                 sclk_sample_en,
    input  logic                 spi_miso,
    output logic [15:0]          status_word,
    output logic                 status_valid,
    output logic [DATA_BITS-1:0] ch_data,
    output logic [2:0]           ch_id,
    output logic                 ch_valid,
    input  logic                 ch_ready,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [7:0]           overflow_count,
    output logic                 busy
);
    localparam int CNT_W   = $clog2(WORD_BITS + 1);
    localparam int IDX_W   = $clog2(NUM_WORDS);
    localparam int ENTRY_W = 3 + DATA_BITS;

    logic [1:0]           rst_sync_q;
    logic                 w_rst_n;
    rx_state_e            state_q;
    logic [WORD_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [IDX_W-1:0]     word_idx_q;
    logic [15:0]          status_word_q;
    logic                 status_valid_q;
    logic                 frame_done_q;
    logic                 frame_abort_q;
    logic [7:0]           overflow_q;
    logic                 w_push;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_head;

    // Reset asserts asynchronously but releases two clocks after reset_n rises.
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign w_rst_n = rst_sync_q[1];

    always_ff @(posedge synthesized_clock_4_167Mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q        <= ST_IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            word_idx_q     <= '0;
            status_word_q  <= '0;
            status_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_abort_q  <= 1'b0;
        end else begin
            status_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_abort_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!spi_cs_n) begin
                        state_q    <= ST_SHIFT;
                        bit_cnt_q  <= '0;
                        word_idx_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (spi_cs_n) begin
                        state_q       <= ST_ABORT;
                        frame_abort_q <= 1'b1;
                    end else if (sclk_sample_en) begin
                        shreg_q   <= {shreg_q[WORD_BITS-2:0], spi_miso};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                            state_q <= ST_STORE;
                        end
                    end
                end
                ST_STORE: begin
                    if (word_idx_q == '0) begin
                        status_word_q  <= shreg_q[WORD_BITS-1 -: 16];
                        status_valid_q <= 1'b1;
                    end
                    if (word_idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end else begin
                        state_q    <= ST_SHIFT;
                        word_idx_q <= word_idx_q + IDX_W'(1);
                        bit_cnt_q  <= '0;
                    end
                end
                ST_DONE: begin
                    if (spi_cs_n) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_push      = (state_q == ST_STORE) && (word_idx_q != '0);
    assign w_push_data = {3'(word_idx_q - IDX_W'(1)), shreg_q[WORD_BITS-1 -: DATA_BITS]};
    assign w_drop      = w_push && w_full && !(ch_ready && !w_empty);

    always_ff @(posedge synthesized_clock_4_167Mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            overflow_q <= '0;
        end else if (w_drop && (overflow_q != 8'hFF)) begin
            overflow_q <= overflow_q + 8'd1;
        end
    end

    ads131_sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (synthesized_clock_4_167Mhz),
        .rst_n_i     (w_rst_n),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (ch_ready),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign status_word    = status_word_q;
    assign status_valid   = status_valid_q;
    assign frame_done     = frame_done_q;
    assign frame_abort    = frame_abort_q;
    assign overflow_count = overflow_q;
    assign busy           = (state_q != ST_IDLE);
    assign ch_valid       = !w_empty;
    assign {ch_id, ch_data} = w_head;

endmodule

`default_nettype wire
